// File: rtl/debug_event_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : debug_event_detect                                           |
// | Description : Synchronises and debounces an asynchronous debug signal,     |
// |               emitting single-cycle rise/fall/glitch pulses and counting   |
// |               accepted rising events.                                      |
// |               Legal ranges: SYNC_STAGES 2..4, FILTER_CYCLES 2..15.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module debug_event_detect #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 async_in,
    input  logic                 enable,
    input  logic                 count_clear,
    output logic                 level_out,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic                 glitch_pulse,
    output logic [CNT_WIDTH-1:0] event_count,
    output logic                 overflow
);

    localparam logic [3:0] c_QCNT_LAST = 4'(FILTER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        QUAL_HIGH = 2'd1,
        ST_HIGH   = 2'd2,
        QUAL_LOW  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_qcnt;
    logic [3:0]             w_qcnt_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_glitch;
    logic                   w_count_rise;

    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_glitch;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_ovf;

    // async_in is touched only by the first synchroniser stage
    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state <= ST_LOW;
            r_qcnt  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_qcnt  <= w_qcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_qcnt_nxt  = r_qcnt;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_glitch    = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (w_s) begin
                    w_state_nxt = QUAL_HIGH;
                    w_qcnt_nxt  = 4'd1;
                end
            end
            QUAL_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = ST_LOW;
                    w_qcnt_nxt  = 4'd0;
                    w_glitch    = 1'b1;
                end else if (r_qcnt == c_QCNT_LAST) begin
                    w_state_nxt = ST_HIGH;
                    w_qcnt_nxt  = 4'd0;
                    w_rise      = 1'b1;
                end else begin
                    w_qcnt_nxt  = r_qcnt + 4'd1;
                end
            end
            ST_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = QUAL_LOW;
                    w_qcnt_nxt  = 4'd1;
                end
            end
            QUAL_LOW: begin
                if (w_s) begin
                    w_state_nxt = ST_HIGH;
                    w_qcnt_nxt  = 4'd0;
                    w_glitch    = 1'b1;
                end else if (r_qcnt == c_QCNT_LAST) begin
                    w_state_nxt = ST_LOW;
                    w_qcnt_nxt  = 4'd0;
                    w_fall      = 1'b1;
                end else begin
                    w_qcnt_nxt  = r_qcnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_qcnt_nxt  = 4'd0;
            end
        endcase
    end

    assign w_count_rise = w_rise & enable;

    // level keeps tracking while disabled; only pulses and counting are gated
    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            if (w_rise) begin
                r_level <= 1'b1;
            end else if (w_fall) begin
                r_level <= 1'b0;
            end
            r_rise   <= w_rise & enable;
            r_fall   <= w_fall & enable;
            r_glitch <= w_glitch & enable;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (count_clear) begin
            r_cnt <= w_count_rise ? CNT_WIDTH'(1) : '0;
            r_ovf <= 1'b0;
        end else if (w_count_rise) begin
            if (&r_cnt) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign level_out    = r_level;
    assign rise_pulse   = r_rise;
    assign fall_pulse   = r_fall;
    assign glitch_pulse = r_glitch;
    assign event_count  = r_cnt;
    assign overflow     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_debug_event_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_debug_event_detect                                        |
// | Description : Bench for debug_event_detect (default and 4-bit counters).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_debug_event_detect;

    localparam int c_SYNC = 2;
    localparam int c_FILT = 4;
    localparam int c_LAT  = c_SYNC + c_FILT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nReset;
    logic        async_in;
    logic        enable;
    logic        count_clear;

    logic        level_a, rise_a, fall_a, glitch_a, ovf_a;
    logic [15:0] cnt_a;
    logic        level_b, rise_b, fall_b, glitch_b, ovf_b;
    logic [3:0]  cnt_b;

    debug_event_detect dut_a (
        .clk          (clk),
        .nReset       (nReset),
        .async_in     (async_in),
        .enable       (enable),
        .count_clear  (count_clear),
        .level_out    (level_a),
        .rise_pulse   (rise_a),
        .fall_pulse   (fall_a),
        .glitch_pulse (glitch_a),
        .event_count  (cnt_a),
        .overflow     (ovf_a)
    );

    debug_event_detect #(.CNT_WIDTH(4)) dut_b (
        .clk          (clk),
        .nReset       (nReset),
        .async_in     (async_in),
        .enable       (enable),
        .count_clear  (count_clear),
        .level_out    (level_b),
        .rise_pulse   (rise_b),
        .fall_pulse   (fall_b),
        .glitch_pulse (glitch_b),
        .event_count  (cnt_b),
        .overflow     (ovf_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: inputs delayed through a queue, then a run-length debouncer
    bit          m_pipe[$];
    bit          m_level;
    int          m_run;
    bit          m_rise, m_fall, m_glitch;
    logic [15:0] m_cnt_a;
    logic [3:0]  m_cnt_b;
    bit          m_ovf_a, m_ovf_b;

    task automatic model_edge();
        bit s;
        bit acc_rise;
        bit acc_fall;
        if (!nReset) begin
            m_pipe = {};
            repeat (c_SYNC) m_pipe.push_back(1'b0);
            m_level = 1'b0; m_run = 0;
            m_rise = 1'b0; m_fall = 1'b0; m_glitch = 1'b0;
            m_cnt_a = 16'd0; m_cnt_b = 4'd0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
        end else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(async_in);
            acc_rise = 1'b0; acc_fall = 1'b0; m_glitch = 1'b0;
            if (s != m_level) begin
                m_run++;
                if (m_run == c_FILT) begin
                    m_level  = s;
                    m_run    = 0;
                    acc_rise = s;
                    acc_fall = !s;
                end
            end else if (m_run != 0) begin
                m_run    = 0;
                m_glitch = 1'b1;
            end
            m_rise   = acc_rise && enable;
            m_fall   = acc_fall && enable;
            m_glitch = m_glitch && enable;
            if (count_clear) begin
                m_cnt_a = m_rise ? 16'd1 : 16'd0; m_ovf_a = 1'b0;
                m_cnt_b = m_rise ? 4'd1 : 4'd0;   m_ovf_b = 1'b0;
            end else if (m_rise) begin
                if (m_cnt_a == 16'hFFFF) m_ovf_a = 1'b1; else m_cnt_a = m_cnt_a + 16'd1;
                if (m_cnt_b == 4'd15)    m_ovf_b = 1'b1; else m_cnt_b = m_cnt_b + 4'd1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        nReset = 1'b0; async_in = 1'b1; enable = 1'b1; count_clear = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({level_a, rise_a, fall_a, glitch_a, ovf_a, cnt_a} !== 21'd0) begin
            n_errors++;
            $display("FAIL reset_a got %h want 0", {level_a, rise_a, fall_a, glitch_a, ovf_a, cnt_a});
        end
        n_checks++;
        if ({level_b, rise_b, fall_b, glitch_b, ovf_b, cnt_b} !== 9'd0) begin
            n_errors++;
            $display("FAIL reset_b got %h want 0", {level_b, rise_b, fall_b, glitch_b, ovf_b, cnt_b});
        end
        async_in = 1'b0; nReset = 1'b1;
        repeat (4) tick();
        n_checks++;
        if ({level_a, rise_a, fall_a, glitch_a} !== 4'd0) begin
            n_errors++;
            $display("FAIL idle_after_reset got %b want 0000", {level_a, rise_a, fall_a, glitch_a});
        end
    endtask

    task automatic test_rise();
        async_in = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++;
            if (rise_a !== 1'(e == c_LAT) || level_a !== 1'(e >= c_LAT) || glitch_a !== 1'b0) begin
                n_errors++;
                $display("FAIL rise_edge%0d got r=%b l=%b g=%b want r=%b l=%b g=0",
                         e, rise_a, level_a, glitch_a, e == c_LAT, e >= c_LAT);
            end
        end
        n_checks++;
        if (cnt_a !== 16'd1 || cnt_b !== 4'd1) begin
            n_errors++;
            $display("FAIL rise_count got %0d/%0d want 1/1", cnt_a, cnt_b);
        end
    endtask

    task automatic test_fall();
        async_in = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++;
            if (fall_a !== 1'(e == c_LAT) || level_a !== 1'(e < c_LAT) || rise_a !== 1'b0) begin
                n_errors++;
                $display("FAIL fall_edge%0d got f=%b l=%b r=%b want f=%b l=%b r=0",
                         e, fall_a, level_a, rise_a, e == c_LAT, e < c_LAT);
            end
        end
        n_checks++;
        if (cnt_a !== 16'd1) begin
            n_errors++;
            $display("FAIL fall_count got %0d want 1", cnt_a);
        end
    endtask

    task automatic test_glitch();
        async_in = 1'b1;
        repeat (3) tick();
        async_in = 1'b0;
        for (int e = 4; e <= 12; e++) begin
            tick();
            n_checks++;
            if (glitch_a !== 1'(e == c_LAT) || rise_a !== 1'b0 || level_a !== 1'b0) begin
                n_errors++;
                $display("FAIL glitch_edge%0d got g=%b r=%b l=%b want g=%b r=0 l=0",
                         e, glitch_a, rise_a, level_a, e == c_LAT);
            end
        end
        n_checks++;
        if (cnt_a !== 16'd1) begin
            n_errors++;
            $display("FAIL glitch_count got %0d want 1", cnt_a);
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        for (int ph = 0; ph < 2; ph++) begin
            async_in = (ph == 0);
            for (int e = 1; e <= 8; e++) begin
                tick();
                n_checks++;
                if ({rise_a, fall_a, glitch_a} !== 3'b000 ||
                    level_a !== 1'((ph == 0) ? (e >= c_LAT) : (e < c_LAT))) begin
                    n_errors++;
                    $display("FAIL enable_ph%0d_edge%0d got l=%b pulses=%b", ph, e,
                             level_a, {rise_a, fall_a, glitch_a});
                end
            end
        end
        n_checks++;
        if (cnt_a !== 16'd1 || cnt_b !== 4'd1) begin
            n_errors++;
            $display("FAIL enable_count got %0d/%0d want 1/1", cnt_a, cnt_b);
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_qual();
        async_in = 1'b1;
        repeat (4) tick();
        nReset = 1'b0;
        tick();
        n_checks++;
        if ({level_a, rise_a, fall_a, glitch_a, ovf_a, cnt_a} !== 21'd0) begin
            n_errors++;
            $display("FAIL midqual_reset got %h want 0", {level_a, rise_a, fall_a, glitch_a, ovf_a, cnt_a});
        end
        nReset = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++;
            if (rise_a !== 1'(e == c_LAT) || glitch_a !== 1'b0) begin
                n_errors++;
                $display("FAIL midqual_edge%0d got r=%b g=%b want r=%b g=0", e, rise_a, glitch_a, e == c_LAT);
            end
        end
        async_in = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_saturate();
        count_clear = 1'b1;
        tick();
        count_clear = 1'b0;
        n_checks++;
        if (cnt_b !== 4'd0 || ovf_b !== 1'b0 || cnt_a !== 16'd0) begin
            n_errors++;
            $display("FAIL clear got b=%0d/%b a=%0d want 0/0 0", cnt_b, ovf_b, cnt_a);
        end
        for (int r = 0; r < 16; r++) begin
            async_in = 1'b1; repeat (8) tick();
            async_in = 1'b0; repeat (8) tick();
        end
        n_checks++;
        if (cnt_b !== 4'd15 || ovf_b !== 1'b1) begin
            n_errors++;
            $display("FAIL saturate_b got %0d/%b want 15/1", cnt_b, ovf_b);
        end
        n_checks++;
        if (cnt_a !== 16'd16 || ovf_a !== 1'b0) begin
            n_errors++;
            $display("FAIL saturate_a got %0d/%b want 16/0", cnt_a, ovf_a);
        end
        async_in = 1'b1;
        for (int e = 1; e <= c_LAT; e++) begin
            count_clear = (e == c_LAT);
            tick();
        end
        count_clear = 1'b0;
        n_checks++;
        if (cnt_b !== 4'd1 || ovf_b !== 1'b0 || cnt_a !== 16'd1 || rise_b !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_with_rise got b=%0d/%b a=%0d r=%b want 1/0 1 1", cnt_b, ovf_b, cnt_a, rise_b);
        end
        async_in = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                async_in = 1'($urandom_range(0, 1));
                hold     = $urandom_range(1, 7);
            end
            hold--;
            enable      = ($urandom_range(0, 9) != 0);
            count_clear = ($urandom_range(0, 59) == 0);
            nReset      = ($urandom_range(0, 299) != 0);
            tick();
            n_checks++;
            if ({level_a, rise_a, fall_a, glitch_a, ovf_a, cnt_a} !==
                {m_level, m_rise, m_fall, m_glitch, m_ovf_a, m_cnt_a}) begin
                n_errors++;
                $display("FAIL random_a cyc%0d got %h want %h", c,
                         {level_a, rise_a, fall_a, glitch_a, ovf_a, cnt_a},
                         {m_level, m_rise, m_fall, m_glitch, m_ovf_a, m_cnt_a});
            end
            n_checks++;
            if ({level_b, rise_b, fall_b, glitch_b, ovf_b, cnt_b} !==
                {m_level, m_rise, m_fall, m_glitch, m_ovf_b, m_cnt_b}) begin
                n_errors++;
                $display("FAIL random_b cyc%0d got %h want %h", c,
                         {level_b, rise_b, fall_b, glitch_b, ovf_b, cnt_b},
                         {m_level, m_rise, m_fall, m_glitch, m_ovf_b, m_cnt_b});
            end
            n_checks++;
            if ($countones({rise_a, fall_a, glitch_a}) > 1) begin
                n_errors++;
                $display("FAIL exclusive cyc%0d got %b want at most one", c, {rise_a, fall_a, glitch_a});
            end
        end
        nReset = 1'b1; enable = 1'b1; count_clear = 1'b0;
    endtask

    initial begin
        nReset = 1'b0; async_in = 1'b0; enable = 1'b1; count_clear = 1'b0;
        test_reset();
        test_rise();
        test_fall();
        test_glitch();
        test_enable();
        test_reset_mid_qual();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
